// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver/transmitter FSM state codes.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int IDX_W     = $clog2(DATA_BITS);

   typedef logic [DATA_BITS-1:0] data_t;
   typedef logic [2:0]           state_t;

   // Kept as plain constants so legacy code comparing raw 3-bit codes still matches.
   localparam state_t s_IDLE         = 3'd0;
   localparam state_t s_RX_START_BIT = 3'd1;
   localparam state_t s_RX_DATA_BITS = 3'd2;
   localparam state_t s_RX_STOP_BIT  = 3'd3;
   localparam state_t s_CLEANUP      = 3'd4;
   localparam state_t s_BREAK        = 3'd5;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus from uart_rx to its consumer; no backpressure, consumer takes the byte on o_Rx_DV.
interface uart_rx_if;
   import uart_pkg::*;

   logic  o_Rx_DV;
   data_t o_Rx_Byte;
   logic  o_Rx_Frame_Err;
   logic  o_Rx_Active;

   modport master (output o_Rx_DV, output o_Rx_Byte, output o_Rx_Frame_Err, output o_Rx_Active);
   modport slave  (input  o_Rx_DV, input  o_Rx_Byte, input  o_Rx_Frame_Err, input  o_Rx_Active);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Sync
);

   logic meta;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta   <= RESET_VAL;
         o_Sync <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignments make this a true two-stage pipeline; blocking ones would collapse it to one flop.
         meta   <= i_Async;
         o_Sync <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, validates the start bit at mid-bit and samples each bit at its centre.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 870,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic      i_Clock,
   input  logic      i_Rst_n,
   input  logic      i_Rx_Serial,
   uart_rx_if.master rx_if
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic             rx_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   data_t            shift_reg;
   data_t            rx_byte;
   logic             rx_dv;
   logic             rx_err;
   logic             rx_active;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Async (i_Rx_Serial),
      .o_Sync  (rx_s)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= s_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift_reg <= '0;
         rx_byte   <= '0;
         rx_dv     <= 1'b0;
         rx_err    <= 1'b0;
         rx_active <= 1'b0;
      end else begin
         // NOTE: strobes default low here and are set only on the deciding cycle, so each lasts exactly one clock.
         rx_dv  <= 1'b0;
         rx_err <= 1'b0;

         case (state)
            s_IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (!rx_s) state <= s_RX_START_BIT;
            end

            s_RX_START_BIT: begin
               if (cnt == HALF_CNT) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state     <= s_RX_DATA_BITS;
                     rx_active <= 1'b1;
                  end else begin
                     state <= s_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            s_RX_DATA_BITS: begin
               if (cnt == LAST_CNT) begin
                  cnt            <= '0;
                  shift_reg[idx] <= rx_s;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= s_RX_STOP_BIT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            s_RX_STOP_BIT: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (rx_s) begin
                     rx_byte <= shift_reg;
                     rx_dv   <= 1'b1;
                     state   <= s_CLEANUP;
                  end else begin
                     rx_err <= 1'b1;
                     state  <= s_BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            s_CLEANUP: begin
               rx_active <= 1'b0;
               state     <= s_IDLE;
            end

            // A line held low after a bad stop bit must go high before a new start is accepted.
            s_BREAK: begin
               rx_active <= 1'b0;
               if (rx_s) state <= s_IDLE;
            end

            default: state <= s_IDLE;
         endcase
      end
   end

   assign rx_if.o_Rx_DV        = rx_dv;
   assign rx_if.o_Rx_Byte      = rx_byte;
   assign rx_if.o_Rx_Frame_Err = rx_err;
   assign rx_if.o_Rx_Active    = rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-banged 8N1 frames, byte-level scoreboard, protocol and timing checks.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 16;
   localparam int LAT = 2 + (CPB - 1) / 2 + 9 * CPB + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;

   uart_rx_if rx_if ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Rx_Serial (rx),
      .rx_if       (rx_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes a correct receiver must deliver, in order, plus the last good byte.
   logic [7:0]  exp_q[$];
   logic [7:0]  last_good   = 8'h00;
   int          dv_cnt      = 0;
   int          err_cnt     = 0;
   int unsigned cyc         = 0;
   int unsigned dv_cyc      = 0;
   int unsigned fall_cyc    = 0;
   bit          active_seen = 1'b0;
   bit          prev_dv     = 1'b0;
   bit          prev_err    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.o_Rx_DV) begin
         dv_cnt++;
         dv_cyc = cyc;
         check("dv_one_cycle", 32'(prev_dv), 0);
         check("dv_err_exclusive", 32'(rx_if.o_Rx_Frame_Err), 0);
         if (exp_q.size() == 0) begin
            check("dv_expected", exp_q.size(), 1);
         end else begin
            last_good = exp_q.pop_front();
            check("rx_byte", 32'(rx_if.o_Rx_Byte), 32'(last_good));
         end
      end
      if (rx_if.o_Rx_Frame_Err) begin
         err_cnt++;
         check("err_one_cycle", 32'(prev_err), 0);
      end
      if (rx_if.o_Rx_Active) active_seen = 1'b1;
      prev_dv  = rx_if.o_Rx_DV;
      prev_err = rx_if.o_Rx_Frame_Err;
   end

   // Drives one frame starting at the current negedge; returns on the negedge after the stop bit.
   task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
      fall_cyc = cyc;
      rx = 1'b0;
      repeat (per) @(negedge clk);
      for (int i = 0; i < DATA_BITS; i++) begin
         rx = b[i];
         repeat (per) @(negedge clk);
      end
      rx = stop_bit;
      repeat (per) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] b, input int per);
      exp_q.push_back(b);
      send_frame(b, per, 1'b1);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
      $fatal(1, "cycle budget exhausted");
   end

   initial begin
      int d0, e0, lat;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      check("reset_dv", 32'(rx_if.o_Rx_DV), 0);
      check("reset_err", 32'(rx_if.o_Rx_Frame_Err), 0);
      check("reset_active", 32'(rx_if.o_Rx_Active), 0);
      check("reset_byte", 32'(rx_if.o_Rx_Byte), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single byte with latency bound
      d0 = dv_cnt; e0 = err_cnt;
      send_good(8'hA5, CPB);
      repeat (20) @(negedge clk);
      check("t1_dv_count", dv_cnt - d0, 1);
      check("t1_err_count", err_cnt - e0, 0);
      check("t1_byte", 32'(rx_if.o_Rx_Byte), 32'h A5);
      lat = int'(dv_cyc - fall_cyc);
      check("t1_latency_within_bound", 32'(lat >= LAT - 1 && lat <= LAT + 1), 1);

      // Back-to-back frames, zero idle gap
      d0 = dv_cnt; e0 = err_cnt;
      send_good(8'h00, CPB);
      send_good(8'hFF, CPB);
      send_good(8'h55, CPB);
      repeat (20) @(negedge clk);
      check("t2_dv_count", dv_cnt - d0, 3);
      check("t2_err_count", err_cnt - e0, 0);
      check("t2_last_byte", 32'(rx_if.o_Rx_Byte), 32'h55);

      // Short low glitch on an idle line
      d0 = dv_cnt; e0 = err_cnt; active_seen = 1'b0;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("t3_dv_count", dv_cnt - d0, 0);
      check("t3_err_count", err_cnt - e0, 0);
      check("t3_active_seen", 32'(active_seen), 0);

      // Bad stop bit followed by a held-low line
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(8'h3C, CPB, 1'b0);
      active_seen = 1'b0;
      repeat (40) @(negedge clk);
      check("t4_err_count", err_cnt - e0, 1);
      check("t4_dv_count", dv_cnt - d0, 0);
      check("t4_no_frame_while_low", 32'(active_seen), 0);
      check("t4_byte_held", 32'(rx_if.o_Rx_Byte), 32'(last_good));
      rx = 1'b1;
      repeat (10) @(negedge clk);
      d0 = dv_cnt;
      send_good(8'h81, CPB);
      repeat (20) @(negedge clk);
      check("t4_recover_dv", dv_cnt - d0, 1);
      check("t4_recover_byte", 32'(rx_if.o_Rx_Byte), 32'h81);

      // Reset during data bit 4; upper nibble all ones so the tail cannot look like a start bit
      d0 = dv_cnt; e0 = err_cnt;
      b = {4'hF, 4'($urandom)};
      fork
         send_frame(b, CPB, 1'b1);
         begin
            repeat (CPB * 5 + 6) @(negedge clk);
            check("t5_active_before_reset", 32'(rx_if.o_Rx_Active), 1);
            rst_n = 1'b0;
            #1;
            check("t5_reset_dv", 32'(rx_if.o_Rx_DV), 0);
            check("t5_reset_err", 32'(rx_if.o_Rx_Frame_Err), 0);
            check("t5_reset_active", 32'(rx_if.o_Rx_Active), 0);
            check("t5_reset_byte", 32'(rx_if.o_Rx_Byte), 0);
            last_good = 8'h00;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      check("t5_no_dv", dv_cnt - d0, 0);
      check("t5_no_err", err_cnt - e0, 0);
      d0 = dv_cnt;
      send_good(8'h7E, CPB);
      repeat (20) @(negedge clk);
      check("t5_recover_dv", dv_cnt - d0, 1);
      check("t5_recover_byte", 32'(rx_if.o_Rx_Byte), 32'h7E);

      // Baud mismatch: sender bit period 15 and 17 cycles
      d0 = dv_cnt; e0 = err_cnt;
      send_good(8'hC3, CPB - 1);
      repeat (20) @(negedge clk);
      send_good(8'hC3, CPB + 1);
      repeat (20) @(negedge clk);
      check("t6_dv_count", dv_cnt - d0, 2);
      check("t6_err_count", err_cnt - e0, 0);
      check("t6_byte", 32'(rx_if.o_Rx_Byte), 32'hC3);

      // Random bytes with random idle gaps
      d0 = dv_cnt; e0 = err_cnt;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         send_good(b, CPB);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("rand_queue_drained", exp_q.size(), 0);
      check("rand_dv_count", dv_cnt - d0, 16);
      check("rand_err_count", err_cnt - e0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
